// File: rtl/diannao_slice_ctrl.sv
// Issue/alignment sequencer for the single-slice DianNao NFU pipeline.
// Optional cycle counter output o_perf_cycles is enabled by defining DIANNAO_CTRL_PERF_EN.
module diannao_slice_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int CNT_WIDTH  = 8,
    parameter int N_OPS      = 1,
    parameter int PIPE_LAT   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [CNT_WIDTH-1:0]  i_num_in,
    input  logic [CNT_WIDTH-1:0]  i_num_out,
    input  logic [N_OPS-1:0]      i_op,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_rd_en,
    output logic                  o_rd_seed,
    output logic [ADDR_WIDTH-1:0] o_nbin_addr,
    output logic [ADDR_WIDTH-1:0] o_sb_addr,
    output logic                  o_load,
    output logic [N_OPS-1:0]      o_op,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr
`ifdef DIANNAO_CTRL_PERF_EN
   ,output logic [31:0]           o_perf_cycles
`endif
);

    localparam int CW1 = CNT_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                r_state;
    logic [CNT_WIDTH-1:0]  r_numIn;
    logic [CNT_WIDTH-1:0]  r_numOut;
    logic [CW1-1:0]        r_k;
    logic [CW1-1:0]        r_n;
    logic                  r_last;
    logic                  r_lastN;
    logic [ADDR_WIDTH-1:0] r_sbNext;
    logic [PIPE_LAT-1:0]   r_loadPipe;
    logic [PIPE_LAT:0]     r_wrPipe;
    logic [PIPE_LAT:0]     r_finalPipe;
    logic [ADDR_WIDTH-1:0] r_addrPipe [PIPE_LAT+1];

    // r_k/r_n/r_last/r_lastN describe the slot currently presented on the read outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_numIn     <= '0;
            r_numOut    <= '0;
            r_k         <= '0;
            r_n         <= '0;
            r_last      <= 1'b0;
            r_lastN     <= 1'b0;
            r_sbNext    <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_rd_en     <= 1'b0;
            o_rd_seed   <= 1'b0;
            o_nbin_addr <= '0;
            o_sb_addr   <= '0;
            o_op        <= '0;
            r_loadPipe  <= '0;
            r_wrPipe    <= '0;
            r_finalPipe <= '0;
            for (int i = 0; i <= PIPE_LAT; i++) r_addrPipe[i] <= '0;
        end else begin
            // Delay lines carry the issue-time tags out to the datapath timing.
            r_loadPipe[0]  <= o_rd_en & ~o_rd_seed;
            r_wrPipe[0]    <= o_rd_en & r_last;
            r_finalPipe[0] <= o_rd_en & r_last & r_lastN;
            r_addrPipe[0]  <= ADDR_WIDTH'(r_n);
            for (int i = 1; i < PIPE_LAT; i++) r_loadPipe[i] <= r_loadPipe[i-1];
            for (int i = 1; i <= PIPE_LAT; i++) begin
                r_wrPipe[i]    <= r_wrPipe[i-1];
                r_finalPipe[i] <= r_finalPipe[i-1];
                r_addrPipe[i]  <= r_addrPipe[i-1];
            end

            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_numIn  <= i_num_in;
                        r_numOut <= i_num_out;
                        o_op     <= i_op;
                        o_busy   <= 1'b1;
                        r_sbNext <= '0;
                        if (i_num_out == '0) begin
                            r_state <= DONE;
                            o_done  <= 1'b1;
                        end else begin
                            r_state     <= RUN;
                            o_rd_en     <= 1'b1;
                            o_rd_seed   <= 1'b1;
                            o_nbin_addr <= '0;
                            r_k         <= '0;
                            r_n         <= '0;
                            r_last      <= (i_num_in == '0);
                            r_lastN     <= (i_num_out == CNT_WIDTH'(1));
                        end
                    end
                end
                RUN: begin
                    if (r_last && r_lastN) begin
                        r_state <= DRAIN;
                        o_rd_en <= 1'b0;
                    end else if (r_last) begin
                        r_n         <= r_n + CW1'(1);
                        r_k         <= '0;
                        o_rd_seed   <= 1'b1;
                        o_nbin_addr <= ADDR_WIDTH'(r_n + CW1'(1));
                        r_last      <= (r_numIn == '0);
                        r_lastN     <= ((r_n + CW1'(2)) == {1'b0, r_numOut});
                    end else begin
                        r_k         <= r_k + CW1'(1);
                        o_rd_seed   <= 1'b0;
                        o_nbin_addr <= ADDR_WIDTH'(r_k);
                        o_sb_addr   <= r_sbNext;
                        r_sbNext    <= r_sbNext + ADDR_WIDTH'(1);
                        r_last      <= ((r_k + CW1'(1)) == {1'b0, r_numIn});
                    end
                end
                DRAIN: begin
                    if (r_wrPipe[PIPE_LAT] && r_finalPipe[PIPE_LAT]) begin
                        r_state <= DONE;
                        o_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    o_done  <= 1'b0;
                    o_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_load    = r_loadPipe[PIPE_LAT-1];
    assign o_wr_en   = r_wrPipe[PIPE_LAT];
    assign o_wr_addr = r_addrPipe[PIPE_LAT];

`ifdef DIANNAO_CTRL_PERF_EN
    logic [31:0] r_perf;

    // Saturating count of busy cycles, restarted by each accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf <= '0;
        end else if (r_state == IDLE && i_start) begin
            r_perf <= '0;
        end else if (o_busy && r_perf != 32'hFFFF_FFFF) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign o_perf_cycles = r_perf;
`else
    // Cycle counter is left out of this build.
`endif

endmodule

// File: doc/diannao_slice_ctrl.md
Name: diannao_slice_ctrl

Overview:
Sequencer for the single-output-slice DianNao NFU pipeline (NFU-1 multiply, NFU-2 add/max, NFU-2/3 accumulator register). It issues NBout-seed and NBin/SB reads, and drives the accumulator load/accumulate select and op select, time-aligned to the datapath latency. It writes each finished output neuron to eDRAM. One job covers num_out output neurons × num_in input chunks (Ti inputs each).

Parameters:
ADDR_WIDTH, 6, width of NBin/SB/eDRAM addresses
CNT_WIDTH, 8, width of job-size counters
N_OPS, 1, width of op select (0 = add/average, 1 = max)
PIPE_LAT, 6, cycles from o_rd_en to the cycle o_load must be valid at the datapath (legal >= 1)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
i_start  in  1  start pulse; sampled only in IDLE
i_num_in  in  CNT_WIDTH  input chunks per output neuron; latched at start
i_num_out  in  CNT_WIDTH  output neurons per job; latched at start
i_op  in  N_OPS  op select; latched at start
o_busy  out  1  job in progress
o_done  out  1  one-cycle job-complete pulse
o_rd_en  out  1  read issue strobe
o_rd_seed  out  1  1 = NBout seed read, 0 = NBin/SB read; valid with o_rd_en
o_nbin_addr  out  ADDR_WIDTH  seed slot: neuron index; data slot: chunk index
o_sb_addr  out  ADDR_WIDTH  running synapse address
o_load  out  1  accumulator select: 0 = load seed (i_nbout), 1 = accumulate NFU-2 result
o_op  out  N_OPS  latched op, held for whole job
o_wr_en  out  1  eDRAM write strobe; result valid at accumulator output this cycle
o_wr_addr  out  ADDR_WIDTH  output neuron index for write

Behaviour:
- Reset: all outputs 0, FSM = IDLE, delay lines cleared. Reset mid-job aborts immediately. No writes after reset.
- FSM: IDLE -> RUN on i_start. If i_num_out == 0, go IDLE -> DONE instead. RUN -> DRAIN after the last issue. DRAIN -> DONE when o_wr_en is asserted for the final neuron. DONE -> IDLE after one cycle.
- Busy and start:
  - o_busy is high in RUN, DRAIN and DONE.
  - o_done is high only in DONE.
  - i_start in a non-IDLE state is ignored.
- Start timing: i_start sampled at cycle 0 edge. First o_rd_en is in cycle 1.
- Issue schedule: per neuron n, num_in+1 consecutive slots. Neurons run back-to-back with no bubbles. Total issue cycles = num_out × (num_in+1).
- Slot 0 (seed): o_rd_seed = 1, o_nbin_addr = n, load tag = 0.
- Slots 1..num_in (data): o_rd_seed = 0, o_nbin_addr = k-1, o_sb_addr = running count starting at 0, load tag = 1.
  - o_sb_addr increments once per data slot across the whole job and holds during seed slots.
- Outside RUN: o_rd_en = 0 and read addresses hold their values.
- Alignment:
  - The load tag is delayed PIPE_LAT cycles to give o_load. o_load = 0 when no tag is present.
  - A last-slot-of-neuron flag is delayed PIPE_LAT+1 cycles to give o_wr_en.
  - o_wr_addr = n of that flag; it is carried through the delay line, not recomputed.
- Addresses wrap modulo 2^ADDR_WIDTH.
- num_in == 0: seed-only neurons; the written result is the seed.
- Max counts: num_in and num_out up to 2^CNT_WIDTH-1 with no overflow. Internal issue counters are CNT_WIDTH+1 bits.

Optional Feature:
- DIANNAO_CTRL_PERF_EN: adds output o_perf_cycles [31:0].
  - Cleared on accepted start; increments every cycle o_busy = 1; saturates at 0xFFFFFFFF; holds its value in IDLE; reset to 0.
- Without the macro, the port does not exist and the logic is absent.

Test Plan:
- Reset: rst high 2 cycles with i_start = 1 -> all outputs 0, no o_rd_en; FSM stays IDLE until rst falls and i_start is seen.
- num_in=2, num_out=1, op=1, start at cycle 0:
  - o_rd_en in cycles 1-3; seed in cycle 1 (nbin_addr 0); data nbin_addr 0,1 / sb_addr 0,1 in cycles 2-3.
  - o_load = 0 in cycle 7, 1 in cycles 8-9.
  - o_wr_en in cycle 10 with wr_addr 0; o_done in cycle 11; o_op = 1 throughout.
- num_in=3, num_out=4:
  - 16 contiguous o_rd_en cycles; sb_addr runs 0..11.
  - o_wr_en 4 cycles apart with wr_addr 0,1,2,3; exactly one o_done.
- num_in=0, num_out=2: 2 seed-only issues; o_load never 1; two o_wr_en with wr_addr 0,1.
- num_out=0 start, plus i_start during a busy job:
  - num_out=0 -> o_done in cycle 1, no o_rd_en or o_wr_en.
  - Second start while busy -> ignored; job count unchanged.
- rst asserted mid-DRAIN with a pending write -> no o_wr_en or o_done after reset; outputs 0; a new job then runs correctly.
